// File: rtl/uart_pkg.sv
// Shared UART types and helpers: line-control decoding and parity computation.
package uart_pkg;

    typedef enum logic [1:0] {
        WL5 = 2'b00,
        WL6 = 2'b01,
        WL7 = 2'b10,
        WL8 = 2'b11
    } word_len_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP,
        WAIT_MARK
    } rx_state_t;

    localparam int OVERSAMPLE_DEFAULT = 16;

    function automatic logic [3:0] data_bits(input word_len_t len);
        return {2'b00, len} + 4'd5;
    endfunction

    // Stick parity forces the bit to ~EPS regardless of the data.
    function automatic logic expected_parity(input logic [7:0] data, input word_len_t len,
                                             input logic eps, input logic stick);
        logic [1:0] len_bits;
        logic [7:0] masked;
        len_bits = len;
        masked   = data & (8'hFF >> (3'd3 - {1'b0, len_bits}));
        if (stick) begin
            return ~eps;
        end
        return eps ? ^masked : ~^masked;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous single-bit inputs with a selectable reset level.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx_frame.sv
// UART receive deframer: oversampled start detection, mid-bit sampling, parity/stop checks
// and a single-cycle strobe per character carrying PE/FE/BI status.
module uart_rx_frame
    import uart_pkg::*;
#(
    parameter int OVERSAMPLE = OVERSAMPLE_DEFAULT,
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  sample_tick,
    input  logic                  rx_enable,
    input  logic                  rxd,
    input  logic [1:0]            word_len,
    input  logic                  parity_en,
    input  logic                  even_parity,
    input  logic                  stick_parity,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_valid,
    output logic                  parity_err,
    output logic                  framing_err,
    output logic                  break_det,
    output logic                  rx_busy
);

    localparam int CW = $clog2(OVERSAMPLE);
    localparam logic [CW-1:0] CNT_MID = CW'(OVERSAMPLE / 2 - 1);
    localparam logic [CW-1:0] CNT_END = CW'(OVERSAMPLE - 1);

    logic rxs;

    sync_2ff #(.RST_VAL(1'b1)) u_rxd_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rxd),
        .q     (rxs)
    );

    rx_state_t             state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [2:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    word_len_t             wl_q, wl_d;
    logic                  pen_q, pen_d;
    logic                  eps_q, eps_d;
    logic                  stick_q, stick_d;
    logic                  pe_q, pe_d;
    logic                  zero_q, zero_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  parity_err_q, parity_err_d;
    logic                  framing_err_q, framing_err_d;
    logic                  break_det_q, break_det_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            bit_cnt_q     <= '0;
            shift_q       <= '0;
            wl_q          <= WL5;
            pen_q         <= 1'b0;
            eps_q         <= 1'b0;
            stick_q       <= 1'b0;
            pe_q          <= 1'b0;
            zero_q        <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            parity_err_q  <= 1'b0;
            framing_err_q <= 1'b0;
            break_det_q   <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            bit_cnt_q     <= bit_cnt_d;
            shift_q       <= shift_d;
            wl_q          <= wl_d;
            pen_q         <= pen_d;
            eps_q         <= eps_d;
            stick_q       <= stick_d;
            pe_q          <= pe_d;
            zero_q        <= zero_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            parity_err_q  <= parity_err_d;
            framing_err_q <= framing_err_d;
            break_det_q   <= break_det_d;
        end
    end

    // zero_q remembers that every bit sampled so far in this frame was 0 (break candidate).
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        bit_cnt_d     = bit_cnt_q;
        shift_d       = shift_q;
        wl_d          = wl_q;
        pen_d         = pen_q;
        eps_d         = eps_q;
        stick_d       = stick_q;
        pe_d          = pe_q;
        zero_d        = zero_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        parity_err_d  = parity_err_q;
        framing_err_d = framing_err_q;
        break_det_d   = break_det_q;

        if (!rx_enable) begin
            state_d   = IDLE;
            cnt_d     = '0;
            bit_cnt_d = '0;
            pe_d      = 1'b0;
            zero_d    = 1'b0;
        end else if (sample_tick) begin
            case (state_q)
                IDLE: begin
                    if (!rxs) begin
                        state_d   = START;
                        cnt_d     = '0;
                        bit_cnt_d = '0;
                        shift_d   = '0;
                        wl_d      = word_len_t'(word_len);
                        pen_d     = parity_en;
                        eps_d     = even_parity;
                        stick_d   = stick_parity;
                        pe_d      = 1'b0;
                        zero_d    = 1'b1;
                    end
                end
                START: begin
                    if (cnt_q == CNT_MID) begin
                        cnt_d     = '0;
                        bit_cnt_d = '0;
                        state_d   = rxs ? IDLE : DATA;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_END) begin
                        cnt_d              = '0;
                        shift_d[bit_cnt_q] = rxs;
                        if (rxs) begin
                            zero_d = 1'b0;
                        end
                        if ({1'b0, bit_cnt_q} == data_bits(wl_q) - 4'd1) begin
                            state_d = pen_q ? PARITY : STOP;
                        end else begin
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                PARITY: begin
                    if (cnt_q == CNT_END) begin
                        cnt_d   = '0;
                        state_d = STOP;
                        if (rxs != expected_parity(8'(shift_q), wl_q, eps_q, stick_q)) begin
                            pe_d = 1'b1;
                        end
                        if (rxs) begin
                            zero_d = 1'b0;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_END) begin
                        cnt_d         = '0;
                        rx_valid_d    = 1'b1;
                        parity_err_d  = pe_q;
                        framing_err_d = !rxs;
                        break_det_d   = zero_q && !rxs;
                        rx_data_d     = (zero_q && !rxs) ? '0 : shift_q;
                        state_d       = rxs ? IDLE : WAIT_MARK;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                WAIT_MARK: begin
                    if (rxs) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign parity_err  = parity_err_q;
    assign framing_err = framing_err_q;
    assign break_det   = break_det_q;
    assign rx_busy     = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: hand-built frames on rxd, strobe contents checked against constants.
module tb_uart_rx_frame;

    logic       clk;
    logic       reset;
    logic       sample_tick;
    logic       rx_enable;
    logic       rxd;
    logic [1:0] word_len;
    logic       parity_en;
    logic       even_parity;
    logic       stick_parity;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       parity_err;
    logic       framing_err;
    logic       break_det;
    logic       rx_busy;

    int   total = 0;
    int   bad = 0;
    int   cyc = 0;
    int   valid_cnt = 0;
    int   valid_cyc = 0;
    int   start_cyc = 0;
    int   bit_clks = 16;
    logic tick_div = 1'b0;
    logic tick_phase = 1'b0;
    logic [7:0] last_data = 8'h00;
    logic last_pe = 1'b0;
    logic last_fe = 1'b0;
    logic last_bi = 1'b0;
    int   base;

    uart_rx_frame #(.OVERSAMPLE(16), .DATA_WIDTH(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_tick  (sample_tick),
        .rx_enable    (rx_enable),
        .rxd          (rxd),
        .word_len     (word_len),
        .parity_en    (parity_en),
        .even_parity  (even_parity),
        .stick_parity (stick_parity),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .parity_err   (parity_err),
        .framing_err  (framing_err),
        .break_det    (break_det),
        .rx_busy      (rx_busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Tick every clock, or every other clock when tick_div is set.
    initial begin
        sample_tick = 1'b1;
        forever begin
            @(negedge clk);
            tick_phase  = ~tick_phase;
            sample_tick = !tick_div || tick_phase;
        end
    end

    // rx_valid is one clock wide, so each strobe is seen on exactly one falling edge.
    always @(negedge clk) begin
        if (rx_valid) begin
            valid_cnt <= valid_cnt + 1;
            valid_cyc <= cyc;
            last_data <= rx_data;
            last_pe   <= parity_err;
            last_fe   <= framing_err;
            last_bi   <= break_det;
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: got timeout required finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h required %0h", tag, got, exp);
        end
    endtask

    task automatic checkStrobe(input string tag, input int b, input logic [7:0] d,
                               input logic pe, input logic fe, input logic bi);
        checkOutput({tag, "_count"}, 32'(valid_cnt - b), 32'd1);
        checkOutput({tag, "_data"}, {24'h0, last_data}, {24'h0, d});
        checkOutput({tag, "_pe"}, {31'h0, last_pe}, {31'h0, pe});
        checkOutput({tag, "_fe"}, {31'h0, last_fe}, {31'h0, fe});
        checkOutput({tag, "_bi"}, {31'h0, last_bi}, {31'h0, bi});
    endtask

    task automatic sendBit(input logic b);
        rxd = b;
        repeat (bit_clks) @(negedge clk);
    endtask

    task automatic setLcr(input logic [1:0] wl, input logic pen, input logic eps, input logic stick);
        word_len     = wl;
        parity_en    = pen;
        even_parity  = eps;
        stick_parity = stick;
    endtask

    // Start bit, LSB-first data, optional parity, one stop bit, then two idle bit-times.
    task automatic applyStimulus(input logic [7:0] data, input int nbits, input logic pen,
                                 input logic pbit, input logic stopb);
        start_cyc = cyc;
        sendBit(1'b0);
        for (int i = 0; i < nbits; i++) sendBit(data[i]);
        if (pen) sendBit(pbit);
        sendBit(stopb);
        sendBit(1'b1);
        sendBit(1'b1);
    endtask

    initial begin
        reset     = 1'b1;
        rx_enable = 1'b1;
        rxd       = 1'b1;
        setLcr(2'b11, 1'b0, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        checkOutput("reset_valid", {31'h0, rx_valid}, 32'd0);
        checkOutput("reset_busy", {31'h0, rx_busy}, 32'd0);
        checkOutput("reset_data", {24'h0, rx_data}, 32'd0);
        checkOutput("reset_flags", {29'h0, parity_err, framing_err, break_det}, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);

        // 8N1 0xA5: strobe lands on the falling edge after clock edge 154 counted from
        // the first edge that sees rxd low (2 sync + 152 ticks), i.e. cyc advance of 155.
        base = valid_cnt;
        applyStimulus(8'hA5, 8, 1'b0, 1'b0, 1'b1);
        checkStrobe("a5", base, 8'hA5, 1'b0, 1'b0, 1'b0);
        checkOutput("a5_latency", 32'(valid_cyc - start_cyc), 32'd155);

        // Five-clock low glitch: START is entered, rejected at the mid-start sample.
        base = valid_cnt;
        rxd = 1'b0;
        repeat (5) @(negedge clk);
        rxd = 1'b1;
        checkOutput("glitch_busy_early", {31'h0, rx_busy}, 32'd1);
        repeat (5) @(negedge clk);
        checkOutput("glitch_busy_tick7", {31'h0, rx_busy}, 32'd1);
        @(negedge clk);
        checkOutput("glitch_busy_tick8", {31'h0, rx_busy}, 32'd0);
        repeat (40) @(negedge clk);
        checkOutput("glitch_no_strobe", 32'(valid_cnt - base), 32'd0);
        checkOutput("glitch_data_kept", {24'h0, rx_data}, 32'hA5);

        // 7E1 0x41 has two ones, so the even parity bit is 0.
        setLcr(2'b10, 1'b1, 1'b1, 1'b0);
        base = valid_cnt;
        applyStimulus(8'h41, 7, 1'b1, 1'b1, 1'b1);
        checkStrobe("7e1_bad", base, 8'h41, 1'b1, 1'b0, 1'b0);
        base = valid_cnt;
        applyStimulus(8'h41, 7, 1'b1, 1'b0, 1'b1);
        checkStrobe("7e1_good", base, 8'h41, 1'b0, 1'b0, 1'b0);
        setLcr(2'b10, 1'b1, 1'b0, 1'b1);
        base = valid_cnt;
        applyStimulus(8'h41, 7, 1'b1, 1'b1, 1'b1);
        checkStrobe("stick_one", base, 8'h41, 1'b0, 1'b0, 1'b0);
        base = valid_cnt;
        applyStimulus(8'h41, 7, 1'b1, 1'b0, 1'b1);
        checkStrobe("stick_zero", base, 8'h41, 1'b1, 1'b0, 1'b0);

        // Framing error with a non-zero character, then a clean frame.
        setLcr(2'b11, 1'b0, 1'b0, 1'b0);
        base = valid_cnt;
        applyStimulus(8'h3C, 8, 1'b0, 1'b0, 1'b0);
        checkStrobe("fe_3c", base, 8'h3C, 1'b0, 1'b1, 1'b0);
        base = valid_cnt;
        applyStimulus(8'h55, 8, 1'b0, 1'b0, 1'b1);
        checkStrobe("after_fe_55", base, 8'h55, 1'b0, 1'b0, 1'b0);

        // Line held low for 40 bit-times: one break strobe, then WAIT_MARK.
        base = valid_cnt;
        rxd = 1'b0;
        repeat (40 * 16) @(negedge clk);
        checkStrobe("break", base, 8'h00, 1'b0, 1'b1, 1'b1);
        checkOutput("break_wait_busy", {31'h0, rx_busy}, 32'd1);
        rxd = 1'b1;
        repeat (32) @(negedge clk);
        checkOutput("break_single", 32'(valid_cnt - base), 32'd1);
        checkOutput("break_idle", {31'h0, rx_busy}, 32'd0);

        // Reset pulse in the middle of data bit 3 of 0xFF.
        base = valid_cnt;
        sendBit(1'b0);
        rxd = 1'b1;
        repeat (3 * 16 + 8) @(negedge clk);
        checkOutput("rst_busy_before", {31'h0, rx_busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checkOutput("rst_busy_after", {31'h0, rx_busy}, 32'd0);
        repeat (6 * 16) @(negedge clk);
        checkOutput("rst_no_strobe", 32'(valid_cnt - base), 32'd0);
        base = valid_cnt;
        applyStimulus(8'h0F, 8, 1'b0, 1'b0, 1'b1);
        checkStrobe("after_rst_0f", base, 8'h0F, 1'b0, 1'b0, 1'b0);

        // rx_enable dropped mid-frame aborts and blocks start detection on a low line.
        base = valid_cnt;
        sendBit(1'b0);
        sendBit(1'b0);
        sendBit(1'b0);
        rx_enable = 1'b0;
        @(negedge clk);
        checkOutput("dis_busy", {31'h0, rx_busy}, 32'd0);
        repeat (4 * 16) @(negedge clk);
        checkOutput("dis_blocked", {31'h0, rx_busy}, 32'd0);
        rxd = 1'b1;
        repeat (32) @(negedge clk);
        rx_enable = 1'b1;
        repeat (32) @(negedge clk);
        checkOutput("dis_no_strobe", 32'(valid_cnt - base), 32'd0);
        base = valid_cnt;
        applyStimulus(8'h3A, 8, 1'b0, 1'b0, 1'b1);
        checkStrobe("after_dis_3a", base, 8'h3A, 1'b0, 1'b0, 1'b0);

        // Ticks on every other clock: 5N1 0x16, then 8O1 0xA5 (four ones, odd bit = 1).
        tick_div = 1'b1;
        bit_clks = 32;
        setLcr(2'b00, 1'b0, 1'b0, 1'b0);
        base = valid_cnt;
        applyStimulus(8'h16, 5, 1'b0, 1'b0, 1'b1);
        checkStrobe("slow_5n1", base, 8'h16, 1'b0, 1'b0, 1'b0);
        setLcr(2'b11, 1'b1, 1'b0, 1'b0);
        base = valid_cnt;
        applyStimulus(8'hA5, 8, 1'b1, 1'b1, 1'b1);
        checkStrobe("slow_8o1", base, 8'hA5, 1'b0, 1'b0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
